// File: rtl/egg_pkg.sv
// -----------------------------------------------------------------------------
// egg_pkg
// Shared definitions for the egg incubator: slot count, hatch delay floor,
// counter/score widths, the spawn FSM state encoding and two small helpers
// (rand-to-delay conversion and a collect-mask population count).
// No ports; imported by egg_slot and egg_incubator.
// -----------------------------------------------------------------------------
package egg_pkg;

    localparam int NSLOT     = 4;
    localparam int MIN_DELAY = 8;
    localparam int CNT_W     = 6;
    localparam int SCORE_W   = 8;
    localparam int RAND_W    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } egg_state_t;

    // Only the low five random bits set the delay, giving 8..39 ticks,
    // which always fits in the 6-bit slot counter.
    function automatic logic [CNT_W-1:0] hatchDelay(input logic [4:0] randLow);
        return CNT_W'(MIN_DELAY) + {1'b0, randLow};
    endfunction

    // Number of slots collected in one cycle (0..NSLOT).
    function automatic logic [2:0] popCount(input logic [NSLOT-1:0] vec);
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < NSLOT; i++) begin
            sum = sum + {2'b00, vec[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/egg_slot.sv
// -----------------------------------------------------------------------------
// egg_slot
// One incubator slot: occupancy flag, hatched flag and the hatch countdown.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         place a new egg with delay loadCnt_i (slot must be free)
//   loadCnt_i      hatch delay in ticks
//   tick_i         game-time enable; counts down an incubating egg
//   collect_i      player collect request for this slot
//   valid_o        slot occupied
//   hatched_o      egg hatched, waiting to be collected
//   collected_o    this cycle's collect actually took a hatched chick
// -----------------------------------------------------------------------------
module egg_slot
    import egg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadCnt_i,
    input  logic             tick_i,
    input  logic             collect_i,
    output logic             valid_o,
    output logic             hatched_o,
    output logic             collected_o
);

    logic             valid_q,   valid_d;
    logic             hatched_q, hatched_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Load only ever targets a free slot and collect only acts on a hatched
    // one, so they never meet; load is still given priority so a freshly
    // loaded egg ignores a coincident tick. Collect beats tick on a hatched
    // slot, and a hatched slot no longer counts.
    always_comb begin
        valid_d   = valid_q;
        hatched_d = hatched_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            valid_d   = 1'b1;
            hatched_d = 1'b0;
            cnt_d     = loadCnt_i;
        end else if (collect_i && hatched_q) begin
            valid_d   = 1'b0;
            hatched_d = 1'b0;
            cnt_d     = '0;
        end else if (tick_i && valid_q && !hatched_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                hatched_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            hatched_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            hatched_q <= hatched_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign hatched_o   = hatched_q;
    assign collected_o = collect_i && hatched_q && !load_i;

endmodule

// File: rtl/egg_incubator.sv
// -----------------------------------------------------------------------------
// egg_incubator
// Turns spawn requests into eggs: strobes the random generator, samples its
// value two cycles later, loads the lowest free slot with the resulting hatch
// delay, and keeps a saturating score of collected chicks.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   spawn_i         one-cycle request for a new egg
//   tick_i          one-cycle game-time enable
//   collect_i       per-slot collect requests
//   rand_i          random value from the generator (bits 6:5 unused)
//   st_o            start strobe to the generator, one cycle per accepted spawn
//   egg_valid_o     slot occupied
//   hatched_o       slot hatched and awaiting collection
//   full_o          every slot occupied
//   spawn_drop_o    one-cycle pulse for a rejected spawn
//   score_o         collected chicks, saturating at 255
// -----------------------------------------------------------------------------
module egg_incubator
    import egg_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               spawn_i,
    input  logic               tick_i,
    input  logic [NSLOT-1:0]   collect_i,
    input  logic [RAND_W-1:0]  rand_i,
    output logic               st_o,
    output logic [NSLOT-1:0]   egg_valid_o,
    output logic [NSLOT-1:0]   hatched_o,
    output logic               full_o,
    output logic               spawn_drop_o,
    output logic [SCORE_W-1:0] score_o
);

    egg_state_t         state_q;
    logic               st_q;
    logic               spawnDrop_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   scoreSum;

    logic [NSLOT-1:0]   validVec;
    logic [NSLOT-1:0]   hatchedVec;
    logic [NSLOT-1:0]   collectedVec;
    logic [NSLOT-1:0]   loadVec;
    logic               freeFound;
    logic               fullNow;
    logic [CNT_W-1:0]   loadCnt;
    logic               unused_rand_bits;

    assign fullNow          = &validVec;
    assign loadCnt          = hatchDelay(rand_i[4:0]);
    assign unused_rand_bits = ^rand_i[6:5];

    // Lowest free slot, judged on the registered occupancy at the start of
    // the LOAD cycle; a slot freed by a collect in that same cycle is only
    // seen as free from the next cycle on.
    always_comb begin
        loadVec   = '0;
        freeFound = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!validVec[i] && !freeFound) begin
                loadVec[i] = (state_q == LOAD);
                freeFound  = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : gSlot
        egg_slot uSlot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (loadVec[g]),
            .loadCnt_i   (loadCnt),
            .tick_i      (tick_i),
            .collect_i   (collect_i[g]),
            .valid_o     (validVec[g]),
            .hatched_o   (hatchedVec[g]),
            .collected_o (collectedVec[g])
        );
    end

    // Spawn sequencer. st and spawn_drop are registered one-cycle pulses
    // produced alongside the state transition. A spawn is never queued: any
    // spawn outside IDLE, or in IDLE while full, is dropped. A LOAD that finds
    // no free slot is also reported as a drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            st_q        <= 1'b0;
            spawnDrop_q <= 1'b0;
        end else begin
            st_q        <= 1'b0;
            spawnDrop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (spawn_i) begin
                        if (fullNow) begin
                            spawnDrop_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            st_q    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state_q     <= WAIT;
                    spawnDrop_q <= spawn_i;
                end
                WAIT: begin
                    state_q     <= LOAD;
                    spawnDrop_q <= spawn_i;
                end
                LOAD: begin
                    state_q     <= IDLE;
                    spawnDrop_q <= spawn_i || !freeFound;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Several chicks may be collected in one cycle; the sum is formed one bit
    // wider so overflow can be clamped to all-ones.
    assign scoreSum = {1'b0, score_q} + {{(SCORE_W-2){1'b0}}, popCount(collectedVec)};

    always_comb begin
        score_d = scoreSum[SCORE_W] ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign st_o         = st_q;
    assign egg_valid_o  = validVec;
    assign hatched_o    = hatchedVec;
    assign full_o       = fullNow;
    assign spawn_drop_o = spawnDrop_q;
    assign score_o      = score_q;

endmodule

// File: tb/tb_egg_incubator.sv
// -----------------------------------------------------------------------------
// tb_egg_incubator
// Drives directed and random play into egg_incubator. Every driven cycle the
// reference model predicts the outputs after the next clock edge and queues
// them; an independent monitor pops one prediction after each edge and
// compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_egg_incubator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spawn = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] collect = 4'b0000;
    logic [6:0] randIn = 7'h00;

    logic       st;
    logic [3:0] eggValid;
    logic [3:0] hatched;
    logic       full;
    logic       spawnDrop;
    logic [7:0] score;

    egg_incubator dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spawn_i      (spawn),
        .tick_i       (tick),
        .collect_i    (collect),
        .rand_i       (randIn),
        .st_o         (st),
        .egg_valid_o  (eggValid),
        .hatched_o    (hatched),
        .full_o       (full),
        .spawn_drop_o (spawnDrop),
        .score_o      (score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic [3:0] valid;
        logic [3:0] hatched;
        logic       full;
        logic       drop;
        logic [7:0] score;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: egg age since an accepted spawn, per-slot remaining
    // ticks, and a plain integer score.
    int   spawnAge = 0;
    bit   mValid[4];
    bit   mHatched[4];
    int   mRemain[4];
    int   mScore = 0;

    function automatic bit allOccupied();
        bit r = 1'b1;
        for (int i = 0; i < 4; i++) if (!mValid[i]) r = 1'b0;
        return r;
    endfunction

    function automatic bit anyIncubating();
        bit r = 1'b0;
        for (int i = 0; i < 4; i++) if (mValid[i] && !mHatched[i]) r = 1'b1;
        return r;
    endfunction

    task automatic modelStep(input bit r, input bit sp, input bit tk,
                             input logic [3:0] col, input logic [6:0] rv);
        exp_t e;
        int   freeSlot = -1;
        int   gained   = 0;
        bit   drop     = 1'b0;
        bit   wasFull;
        if (r) begin
            spawnAge = 0;
            mScore   = 0;
            for (int i = 0; i < 4; i++) begin
                mValid[i] = 0; mHatched[i] = 0; mRemain[i] = 0;
            end
        end else begin
            wasFull = allOccupied();
            for (int i = 0; i < 4; i++) if (!mValid[i] && freeSlot < 0) freeSlot = i;
            if (sp && (spawnAge != 0 || wasFull)) drop = 1'b1;
            if (spawnAge == 3 && freeSlot < 0) drop = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (spawnAge == 3 && i == freeSlot) begin
                    mValid[i] = 1; mHatched[i] = 0; mRemain[i] = 8 + (int'(rv) % 32);
                end else if (col[i] && mHatched[i]) begin
                    mValid[i] = 0; mHatched[i] = 0; mRemain[i] = 0; gained++;
                end else if (tk && mValid[i] && !mHatched[i]) begin
                    mRemain[i]--;
                    if (mRemain[i] == 0) mHatched[i] = 1;
                end
            end
            mScore = (mScore + gained > 255) ? 255 : mScore + gained;
            if (spawnAge == 0) spawnAge = (sp && !wasFull) ? 1 : 0;
            else if (spawnAge == 3) spawnAge = 0;
            else spawnAge++;
        end
        e.st    = (spawnAge == 1);
        e.drop  = drop;
        e.score = 8'(mScore);
        for (int i = 0; i < 4; i++) begin
            e.valid[i]   = mValid[i];
            e.hatched[i] = mHatched[i];
        end
        e.full = allOccupied();
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit r, input bit sp, input bit tk,
                                 input logic [3:0] col, input logic [6:0] rv);
        @(negedge clk);
        rst     = r;
        spawn   = sp;
        tick    = tk;
        collect = col;
        randIn  = rv;
        modelStep(r, sp, tk, col, rv);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
    endtask

    // Random garbage on rand except in the fourth cycle, where it is sampled.
    task automatic spawnEgg(input logic [6:0] rv);
        applyStimulus(0, 1, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, rv);
    endtask

    task automatic ticksToHatch(input int slot, input int expTicks);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < 100) begin
            applyStimulus(0, 0, 1, 4'b0000, 7'($urandom));
            n++;
            @(posedge clk);
            #2;
            if (hatched[slot]) done = 1'b1;
        end
        checkOutput($sformatf("ticks to hatch slot %0d", slot), done ? n : -1, expTicks);
    endtask

    task automatic tickUntilAllHatched();
        int n = 0;
        while (anyIncubating() && n < 200) begin
            applyStimulus(0, 0, 1, 4'b0000, 7'($urandom));
            n++;
        end
        if (anyIncubating()) checkOutput("hatch wait budget", 0, 1);
    endtask

    task automatic readAfterEdge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one prediction is consumed after every clock edge that has one.
    always @(posedge clk) begin : monitorBlk
        exp_t e;
        exp_t a;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = {st, eggValid, hatched, full, spawnDrop, score};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("[TB] FAIL outputs @%0t: got st=%b valid=%b hatched=%b full=%b drop=%b score=%0d, required st=%b valid=%b hatched=%b full=%b drop=%b score=%0d",
                         $time, a.st, a.valid, a.hatched, a.full, a.drop, a.score,
                         e.st, e.valid, e.hatched, e.full, e.drop, e.score);
            end
        end
    end

    initial begin : stimulus
        int guard;
        int gained;
        logic [3:0] mask;

        for (int i = 0; i < 4; i++) begin
            mValid[i] = 0; mHatched[i] = 0; mRemain[i] = 0;
        end

        // Reset held for a few cycles.
        repeat (3) applyStimulus(1, 0, 0, 4'b0000, 7'($urandom));
        idleCycles(2);

        // Delay 13, then 39 and 8 (upper rand bits ignored).
        $display("[TB] single-egg hatch delays");
        spawnEgg(7'h05);
        readAfterEdge();
        checkOutput("egg_valid after first spawn", int'(eggValid), 1);
        ticksToHatch(0, 13);
        applyStimulus(0, 0, 0, 4'b0001, 7'($urandom));
        spawnEgg(7'h7F);
        ticksToHatch(0, 39);
        applyStimulus(0, 0, 0, 4'b0001, 7'($urandom));
        spawnEgg(7'h20);
        ticksToHatch(0, 8);
        applyStimulus(0, 0, 0, 4'b0001, 7'($urandom));
        readAfterEdge();
        checkOutput("score after three chicks", int'(score), 3);

        // Fill all slots, with a spawn attempted during WAIT of the first.
        $display("[TB] fill slots and reject spawns");
        applyStimulus(0, 1, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 1, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
        for (int k = 0; k < 3; k++) spawnEgg(7'($urandom));
        readAfterEdge();
        checkOutput("full after four spawns", int'(full), 1);
        spawnEgg(7'($urandom));
        applyStimulus(0, 0, 1, 4'b1111, 7'($urandom));

        // Collect slot 2 together with a tick once it hatches.
        guard = 0;
        while (!mHatched[2] && guard < 60) begin
            applyStimulus(0, 0, 1, 4'b0000, 7'($urandom));
            guard++;
        end
        if (!mHatched[2]) checkOutput("slot 2 hatch budget", 0, 1);
        applyStimulus(0, 0, 1, 4'b0100, 7'($urandom));
        readAfterEdge();
        checkOutput("slot 2 cleared by collect", int'(eggValid[2]), 0);
        tickUntilAllHatched();
        applyStimulus(0, 0, 0, 4'b1111, 7'($urandom));

        // Reset in the WAIT cycle of a spawn.
        $display("[TB] reset during spawn");
        applyStimulus(0, 1, 0, 4'b0000, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0000, 7'($urandom));
        applyStimulus(1, 0, 0, 4'b0000, 7'($urandom));
        applyStimulus(1, 0, 0, 4'b0000, 7'($urandom));
        idleCycles(6);

        // Random play up to a score of 252.
        $display("[TB] random play");
        guard = 0;
        while (mScore < 252 && guard < 40000) begin
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            gained = 0;
            for (int i = 0; i < 4; i++) if (mask[i] && mHatched[i]) gained++;
            if (mScore + gained > 252) mask = 4'b0000;
            applyStimulus(0, $urandom_range(0, 2) == 0, 1'($urandom), mask, 7'($urandom));
            guard++;
        end
        if (mScore < 252) checkOutput("random play budget", mScore, 252);

        // Saturation: 252 -> 254 -> 255 with a two-slot collect, then hold.
        $display("[TB] score saturation");
        idleCycles(4);
        tickUntilAllHatched();
        guard = 0;
        while (!allOccupied() && guard < 4) begin
            spawnEgg(7'($urandom));
            guard++;
        end
        tickUntilAllHatched();
        applyStimulus(0, 0, 0, 4'b0001, 7'($urandom));
        applyStimulus(0, 0, 0, 4'b0010, 7'($urandom));
        readAfterEdge();
        checkOutput("score before saturating collect", int'(score), 254);
        applyStimulus(0, 0, 1, 4'b1100, 7'($urandom));
        readAfterEdge();
        checkOutput("score saturates", int'(score), 255);
        spawnEgg(7'($urandom));
        tickUntilAllHatched();
        applyStimulus(0, 0, 0, 4'b1111, 7'($urandom));
        idleCycles(2);
        readAfterEdge();
        checkOutput("score holds at 255", int'(score), 255);

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (expQ.size() > 0) checkOutput("monitor drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/egg_incubator.md
# egg_incubator

Downstream consumer of the 7-bit random generator in the eggs-hatch game. On each spawn request it pulses the generator's `st` input, samples the resulting `rand` value, and converts it into a hatch delay for one of four egg slots. It then counts slots down on a game tick, flags hatched eggs, and scores player collections. The display and game-control logic read its slot status and score.

## Interface
- `NSLOT`, 4: number of egg slots (fixed; masks below are 4 bits).
- `MIN_DELAY`, 8: minimum hatch delay in ticks.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spawn`  in  1  one-cycle request to place a new egg.
- `tick`  in  1  one-cycle game-time enable (nominally 1 Hz).
- `collect`  in  4  per-slot collect request from player input.
- `rand`  in  7  random value from the generator.
- `st`  out  1  start strobe to the generator; one cycle per accepted spawn.
- `egg_valid`  out  4  slot occupied (incubating or hatched).
- `hatched`  out  4  slot's egg has hatched and is awaiting collection.
- `full`  out  1  all four slots occupied.
- `spawn_drop`  out  1  one-cycle pulse when a spawn is rejected.
- `score`  out  8  count of collected chicks; saturates at 255.

## Operation
- FSM states: IDLE, REQ, WAIT, LOAD.
  - IDLE → REQ on `spawn && !full`.
  - REQ: `st`=1, then go to WAIT.
  - WAIT: `st`=0; one settle cycle, then go to LOAD.
  - LOAD: write the slot, then return to IDLE.
- Spawn rejection: `spawn` in REQ, WAIT or LOAD, or `spawn` in IDLE with `full`=1, is dropped. `spawn_drop`=1 on the next cycle. No queueing.
- Slot selection in LOAD: lowest-index slot with `egg_valid`=0, using register values at the start of the LOAD cycle.
  - If no slot is free (filled meanwhile by nothing; defensive only), the load is discarded and `spawn_drop` pulses.
- Delay arithmetic: `cnt = MIN_DELAY + rand[4:0]`, range 8..39, held in a 6-bit per-slot counter. `rand[6:5]` are ignored.
- Loaded slot: `egg_valid`=1, `hatched`=0.
- Tick: every slot with `egg_valid && !hatched` decrements. When a counter goes from 1 to 0, that slot's `hatched` is set.
- Collect: `collect[i]` with `hatched[i]`=1 clears `egg_valid[i]`, `hatched[i]` and the counter, and increments `score` (saturating at 255). `collect[i]` on a non-hatched slot is ignored.
- Multiple collects in one cycle add the number of hatched slots collected, saturating at 255.
- `full` = AND of `egg_valid`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `st`, `spawn_drop`, `full`, `score` = 0.
  - `egg_valid`, `hatched` = 0; all counters = 0.
- Reset mid-sequence abandons the spawn; no `st` is issued after reset deasserts until a new `spawn`.
- Spawn latency: `spawn` at cycle 0 gives `st`=1 in cycle 1, `rand` sampled at the end of cycle 3, and `egg_valid` visible in cycle 4. Next spawn accepted from cycle 4.
- Tick in the same cycle as LOAD: the newly loaded slot is not decremented in that cycle.
- Collect and tick in the same cycle on a hatched slot: collect wins; the slot is cleared.
- A slot freed by collect in the LOAD cycle is not eligible for that load; it is usable from the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `egg_pkg`:
  - FSM state encoding (2-bit typedef).
  - `NSLOT`, `MIN_DELAY`.
  - Counter width (6) and score width (8) constants.
- One natural sub-module: `egg_slot`, instantiated 4×. It holds valid, hatched and the counter, with load, tick and collect inputs and a `collected` pulse output.
- Top level holds the FSM, slot selection, and the saturating score adder.

## Test plan
- Reset → all outputs 0. `spawn` at cycle 0 with `rand`=7'h05 → `st` high in cycle 1 only; cycle 4 shows `egg_valid`=4'b0001; the egg hatches after exactly 13 ticks.
- `rand`=7'h7F → delay 39. `rand`=7'h20 → delay 8 (bits 6:5 ignored). Both verified by counting ticks to `hatched`.
- Four spawns fill slots 0..3 and `full`=1. A fifth spawn → `spawn_drop` pulse, no `st`. A spawn during WAIT → `spawn_drop`.
- Collect on hatched slot 2 in the same cycle as tick → slot 2 cleared, `score`+1. Collect on an incubating slot → no change.
- Preload `score`=254, then collect two hatched slots in one cycle → `score`=255 and stays 255.
- Assert `rst` during WAIT → FSM in IDLE, no slot loaded, `st` stays 0 afterwards.
